// File: rtl/ddr_alarm_readbuf_pkg.sv
// Shared definitions for the alarm-record read buffer: record/word widths,
// request FSM states, error flag bit positions and the record word selector.
package ddr_alarm_readbuf_pkg;

  localparam int unsigned RecW  = 128;
  localparam int unsigned WordW = 16;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitHi,
    StWaitLo
  } req_st_e;

  localparam int unsigned ErrOrphan    = 0;
  localparam int unsigned ErrOverwrite = 1;
  localparam int unsigned ErrTimeout   = 2;

  // Word 0 is the most significant timing half-word, word 7 the least
  // significant sample half-word.
  function automatic logic [WordW-1:0] rec_word(input logic [RecW-1:0] rec,
                                                input logic [2:0]      idx);
    return rec[(RecW - 1) - (WordW * idx) -: WordW];
  endfunction

endpackage

// File: rtl/ddr_alarm_readbuf_if.sv
// Host (flexbus) side of the alarm-record read buffer.
//   slave  : seen by the buffer (dump/read/clear requests in, data/status out)
//   master : seen by the host
interface ddr_alarm_readbuf_if;
  import ddr_alarm_readbuf_pkg::*;

  logic             host_dump_L;
  logic             host_dump_H;
  logic [7:0]       host_batches;
  logic             host_rd_en;
  logic [WordW-1:0] host_rd_data;
  logic             host_rd_valid;
  logic             host_empty;
  logic [7:0]       host_rec_level;
  logic             busy;
  logic [2:0]       err_flags;
  logic             host_clr_err;

  modport slave (
    input  host_dump_L, host_dump_H, host_batches, host_rd_en, host_clr_err,
    output host_rd_data, host_rd_valid, host_empty, host_rec_level, busy, err_flags
  );

  modport master (
    output host_dump_L, host_dump_H, host_batches, host_rd_en, host_clr_err,
    input  host_rd_data, host_rd_valid, host_empty, host_rec_level, busy, err_flags
  );

endinterface

// File: rtl/ddr_alarm_readbuf_alarm_rec_fifo.sv
// Single-clock record FIFO with show-ahead read data.
//   clk_i, rst_i         : clock, asynchronous active-high reset (empties FIFO)
//   wr_en_i, wr_data_i   : push (dropped when full)
//   rd_en_i, rd_data_o   : pop (ignored when empty); rd_data_o is the head record
//   full_o, empty_o      : status
//   level_o              : number of stored records
module alarm_rec_fifo #(
  parameter int unsigned Depth = 128,
  parameter int unsigned Width = 128
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [Width-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [Width-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned AW   = $clog2(Depth);
  localparam int unsigned LvlW = AW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_wr, do_rd;

  assign level_o   = wptr_q - rptr_q;
  assign full_o    = (level_o == LvlW'(Depth));
  assign empty_o   = (level_o == '0);
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/ddr_alarm_readbuf.sv
// Alarm-record read buffer: pairs DDR timing/sample words into 128-bit
// records, buffers them, serialises them as 16-bit host words and paces the
// DDR controller with RdStar batch requests while there is room for a batch.
//   clk, rst                        : clock, asynchronous active-high reset
//   ddr_dat_timing / ddr_timing_en  : timing word and its valid level
//   ddr_dat / ddr_dat_en            : sample word and its valid level
//   ddrL/H_read_switch              : controller busy on the selected region
//   ddrL/H_RdStar                   : batch request pulses
//   host                            : host dump/read/status interface
module ddr_alarm_readbuf
  import ddr_alarm_readbuf_pkg::*;
#(
  parameter int unsigned REC_DEPTH  = 128,
  parameter int unsigned BATCH_RECS = 50,
  parameter int unsigned RDSTAR_W   = 4,
  parameter int unsigned WAIT_TMO   = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        ddr_dat_timing,
  input  logic               ddr_timing_en,
  input  logic [63:0]        ddr_dat,
  input  logic               ddr_dat_en,
  input  logic               ddrL_read_switch,
  input  logic               ddrH_read_switch,
  output logic               ddrL_RdStar,
  output logic               ddrH_RdStar,
  ddr_alarm_readbuf_if.slave host
);

  localparam int unsigned LvlW = $clog2(REC_DEPTH) + 1;
  localparam int unsigned CntW = $clog2(RDSTAR_W + 1);
  localparam int unsigned TmoW = $clog2(WAIT_TMO + 1);
  // Highest level that still leaves room for a whole batch.
  localparam logic [LvlW-1:0] MaxLvl = LvlW'(REC_DEPTH - BATCH_RECS);

  // Record pairing and serialiser state.
  logic             tim_en_q, dat_en_q, pend_q, pend_d;
  logic [63:0]      hold_q, hold_d;
  logic [2:0]       err_q, err_d, widx_q, widx_d;
  logic [WordW-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             tim_rise, dat_rise, rd_fire;

  // FIFO.
  logic             fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [RecW-1:0]  fifo_wdata, fifo_rdata;
  logic [LvlW-1:0]  fifo_level;
  logic [31:0]      lvl32;

  // Request FSM.
  req_st_e          state_q;
  logic             bank_q, rdstar_l_q, rdstar_h_q, sw_sel, room, tmo_hit;
  logic [7:0]       batches_q;
  logic [CntW-1:0]  cnt_q;
  logic [TmoW-1:0]  tmo_q;

  always_comb begin
    tim_rise   = ddr_timing_en & ~tim_en_q;
    dat_rise   = ddr_dat_en & ~dat_en_q;
    // A same-cycle timing edge lands in the hold register before the record forms.
    hold_d     = tim_rise ? ddr_dat_timing : hold_q;
    fifo_wr    = dat_rise & (pend_q | tim_rise);
    fifo_wdata = {hold_d, ddr_dat};
    pend_d     = fifo_wr ? 1'b0 : (tim_rise | pend_q);

    err_d = host.host_clr_err ? 3'b000 : err_q;
    if (dat_rise && !(pend_q || tim_rise)) err_d[ErrOrphan]    = 1'b1;
    if (tim_rise && pend_q)                err_d[ErrOverwrite] = 1'b1;
    if (tmo_hit)                           err_d[ErrTimeout]   = 1'b1;

    rd_fire    = host.host_rd_en & ~fifo_empty;
    fifo_rd    = rd_fire & (widx_q == 3'd7);
    widx_d     = rd_fire ? widx_q + 3'd1 : widx_q;
    rd_data_d  = rd_fire ? rec_word(fifo_rdata, widx_q) : rd_data_q;
    rd_valid_d = rd_fire;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tim_en_q   <= 1'b0;
      dat_en_q   <= 1'b0;
      hold_q     <= '0;
      pend_q     <= 1'b0;
      err_q      <= '0;
      widx_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      tim_en_q   <= ddr_timing_en;
      dat_en_q   <= ddr_dat_en;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      widx_q     <= widx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  alarm_rec_fifo #(
    .Depth (REC_DEPTH),
    .Width (RecW)
  ) u_fifo (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign sw_sel  = bank_q ? ddrH_read_switch : ddrL_read_switch;
  assign room    = (fifo_level <= MaxLvl);
  // One timeout counter spans both wait states, measured from REQ exit.
  assign tmo_hit = ((state_q == StWaitHi) || (state_q == StWaitLo)) &&
                   (tmo_q == TmoW'(WAIT_TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bank_q     <= 1'b0;
      batches_q  <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      rdstar_l_q <= 1'b0;
      rdstar_h_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (batches_q != '0) begin
            if (room) begin
              state_q    <= StReq;
              cnt_q      <= '0;
              rdstar_l_q <= ~bank_q;
              rdstar_h_q <= bank_q;
            end
          end else if (host.host_dump_L && host.host_batches != '0) begin
            batches_q <= host.host_batches;
            bank_q    <= 1'b0;
          end else if (host.host_dump_H && host.host_batches != '0) begin
            batches_q <= host.host_batches;
            bank_q    <= 1'b1;
          end
        end
        StReq: begin
          if (cnt_q == CntW'(RDSTAR_W - 1)) begin
            rdstar_l_q <= 1'b0;
            rdstar_h_q <= 1'b0;
            tmo_q      <= '0;
            state_q    <= StWaitHi;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWaitHi: begin
          if (tmo_hit) begin
            batches_q <= '0;
            state_q   <= StIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (sw_sel) state_q <= StWaitLo;
          end
        end
        StWaitLo: begin
          if (tmo_hit) begin
            batches_q <= '0;
            state_q   <= StIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (!sw_sel) begin
              batches_q <= batches_q - 8'd1;
              state_q   <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign lvl32 = 32'(fifo_level);

  assign ddrL_RdStar         = rdstar_l_q;
  assign ddrH_RdStar         = rdstar_h_q;
  assign host.host_rd_data   = rd_data_q;
  assign host.host_rd_valid  = rd_valid_q;
  assign host.host_empty     = fifo_empty;
  assign host.host_rec_level = (lvl32 > 32'd255) ? 8'hFF : lvl32[7:0];
  assign host.busy           = (batches_q != '0) || (state_q != StIdle);
  assign host.err_flags      = err_q;

  // Full never occurs while requests are gated on room; kept for completeness.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_ddr_alarm_readbuf.sv
module tb_ddr_alarm_readbuf;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] tim, dat;
  logic        tim_en, dat_en, sw_l, sw_h;
  logic        rdstar_l, rdstar_h;
  logic [63:0] zero64 = '0;
  logic        zero1  = 1'b0;
  logic        t_rdstar_l, t_rdstar_h;

  ddr_alarm_readbuf_if hif ();
  ddr_alarm_readbuf_if tif ();

  ddr_alarm_readbuf #(
    .REC_DEPTH(128), .BATCH_RECS(50), .RDSTAR_W(4), .WAIT_TMO(65535)
  ) dut (
    .clk(clk), .rst(rst), .ddr_dat_timing(tim), .ddr_timing_en(tim_en), .ddr_dat(dat),
    .ddr_dat_en(dat_en), .ddrL_read_switch(sw_l), .ddrH_read_switch(sw_h),
    .ddrL_RdStar(rdstar_l), .ddrH_RdStar(rdstar_h), .host(hif)
  );

  ddr_alarm_readbuf #(
    .REC_DEPTH(128), .BATCH_RECS(50), .RDSTAR_W(4), .WAIT_TMO(100)
  ) dut_t (
    .clk(clk), .rst(rst), .ddr_dat_timing(zero64), .ddr_timing_en(zero1), .ddr_dat(zero64),
    .ddr_dat_en(zero1), .ddrL_read_switch(zero1), .ddrH_read_switch(zero1),
    .ddrL_RdStar(t_rdstar_l), .ddrH_RdStar(t_rdstar_h), .host(tif)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RdStar pulse monitor.
  int pl_tot = 0, pl_good = 0, ph_tot = 0, ph_good = 0, both_cnt = 0;
  int run_l = 0, run_h = 0;
  initial forever begin
    @(negedge clk);
    if (rdstar_l && rdstar_h) both_cnt++;
    if (rdstar_l) run_l++;
    else if (run_l != 0) begin pl_tot++; if (run_l == 4) pl_good++; run_l = 0; end
    if (rdstar_h) run_h++;
    else if (run_h != 0) begin ph_tot++; if (run_h == 4) ph_good++; run_h = 0; end
  end

  typedef struct {
    logic        te, de, re, cl;
    logic [63:0] t, d;
    logic [15:0] xd;
    logic        xv;
    logic [7:0]  xl;
    logic        xe;
    logic [2:0]  xr;
  } vec_t;
  vec_t vq[$];

  function automatic void addv(input logic te, input logic de, input logic re, input logic cl,
                               input logic [63:0] t, input logic [63:0] d, input logic [15:0] xd,
                               input logic xv, input logic [7:0] xl, input logic xe,
                               input logic [2:0] xr);
    vec_t v;
    v.te = te; v.de = de; v.re = re; v.cl = cl; v.t = t; v.d = d;
    v.xd = xd; v.xv = xv; v.xl = xl; v.xe = xe; v.xr = xr;
    vq.push_back(v);
  endfunction

  logic [127:0] exp_q[$];

  task automatic do_reset();
    rst = 1'b1; tim_en = 0; dat_en = 0; sw_l = 0; sw_h = 0;
    hif.host_rd_en = 0; hif.host_dump_L = 0; hif.host_dump_H = 0; hif.host_clr_err = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic arm(input logic l, input logic h, input logic [7:0] n);
    hif.host_dump_L = l; hif.host_dump_H = h; hif.host_batches = n;
    @(negedge clk);
    hif.host_dump_L = 0; hif.host_dump_H = 0;
  endtask

  task automatic send_rec(input logic [63:0] t, input logic [63:0] d);
    tim = t; tim_en = 1;
    @(negedge clk);
    tim_en = 0; dat = d; dat_en = 1;
    @(negedge clk);
    dat_en = 0;
    @(negedge clk);
    exp_q.push_back({t, d});
  endtask

  task automatic wait_rdstar(input logic h);
    logic seen = 0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (h ? rdstar_h : rdstar_l) seen = 1;
      else @(negedge clk);
    end
    chk("rdstar_seen", seen, 1);
  endtask

  task automatic serve_batch(input logic h, input int n, input int base);
    wait_rdstar(h);
    repeat (2) @(negedge clk);
    if (h) sw_h = 1; else sw_l = 1;
    for (int k = 0; k < n; k++)
      send_rec(64'h1000_0000_0000_0000 + 64'(base + k), 64'h2000_0000_0000_0000 + 64'(base + k));
    sw_l = 0; sw_h = 0;
    @(negedge clk);
  endtask

  task automatic read_recs(input int n);
    logic [127:0] r;
    hif.host_rd_en = 1;
    for (int k = 0; k < n; k++) begin
      r = exp_q.pop_front();
      for (int j = 0; j < 8; j++) begin
        @(negedge clk);
        chk("word_valid", hif.host_rd_valid, 1);
        chk("word_data", hif.host_rd_data, r[127 - 16 * j -: 16]);
      end
    end
    hif.host_rd_en = 0;
  endtask

  task automatic scen_dump2(input logic both);
    int sl, sg, sh;
    sl = pl_tot; sg = pl_good; sh = ph_tot;
    arm(1, both, 8'd2);
    chk("dump2_busy_armed", hif.busy, 1);
    serve_batch(0, 50, 0);
    arm(0, 1, 8'd7);  // ignored while busy
    chk("dump2_level_mid", hif.host_rec_level, 50);
    chk("dump2_busy_mid", hif.busy, 1);
    serve_batch(0, 50, 50);
    repeat (3) @(negedge clk);
    chk("dump2_l_pulses", pl_tot - sl, 2);
    chk("dump2_l_width4", pl_good - sg, 2);
    chk("dump2_h_pulses", ph_tot - sh, 0);
    chk("dump2_level", hif.host_rec_level, 100);
    chk("dump2_busy_end", hif.busy, 0);
    chk("dump2_both_high", both_cnt, 0);
  endtask

  localparam logic [63:0] T1 = 64'h0123_4567_89AB_CDEF, D1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] TA = 64'hAAAA_0000_0000_0001, TB = 64'hBBBB_CCCC_DDDD_EEEE;
  localparam logic [63:0] D2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] T3 = 64'hDEAD_BEEF_0000_0001, D3 = 64'hCAFE_F00D_0000_0002;
  localparam logic [63:0] T4 = 64'h1234_5678_9ABC_DEF0, D4 = 64'h0FED_CBA9_8765_4321;

  initial begin
    logic [15:0] w1 [8];
    logic [15:0] w2 [7];
    logic [15:0] w3 [7];
    int sh, tw;
    logic seen;

    rst = 1; tim = 0; dat = 0; tim_en = 0; dat_en = 0; sw_l = 0; sw_h = 0;
    hif.host_dump_L = 0; hif.host_dump_H = 0; hif.host_batches = 0;
    hif.host_rd_en = 0; hif.host_clr_err = 0;
    tif.host_dump_L = 0; tif.host_dump_H = 0; tif.host_batches = 0;
    tif.host_rd_en = 0; tif.host_clr_err = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);

    chk("rst_rdstar_l", rdstar_l, 0);
    chk("rst_rdstar_h", rdstar_h, 0);
    chk("rst_rd_data", hif.host_rd_data, 0);
    chk("rst_rd_valid", hif.host_rd_valid, 0);
    chk("rst_empty", hif.host_empty, 1);
    chk("rst_level", hif.host_rec_level, 0);
    chk("rst_busy", hif.busy, 0);
    chk("rst_err", hif.err_flags, 0);

    // Pairing, serialiser and error flags, one row per cycle.
    w1 = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    w2 = '{16'hCCCC, 16'hDDDD, 16'hEEEE, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    w3 = '{16'hBEEF, 16'h0000, 16'h0001, 16'hCAFE, 16'hF00D, 16'h0000, 16'h0002};
    addv(1, 0, 0, 0, T1, 0, 0, 0, 0, 1, 3'b000);
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b000);
    addv(0, 1, 0, 0, 0, D1, 0, 0, 1, 0, 3'b000);
    for (int i = 0; i < 8; i++)
      addv(0, 0, 1, 0, 0, 0, w1[i], 1, (i == 7) ? 8'd0 : 8'd1, (i == 7), 3'b000);
    addv(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 3'b000);     // read while empty
    addv(0, 1, 0, 0, 0, D2, 0, 0, 0, 1, 3'b001);    // orphan data
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b001);
    addv(1, 0, 0, 0, TA, 0, 0, 0, 0, 1, 3'b001);
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b001);
    addv(1, 0, 0, 0, TB, 0, 0, 0, 0, 1, 3'b011);    // overwrite
    addv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3'b011);
    addv(0, 1, 0, 0, 0, D2, 0, 0, 1, 0, 3'b011);
    addv(0, 1, 0, 0, 0, D2, 0, 0, 1, 0, 3'b011);    // level held high: no new record
    addv(0, 0, 1, 0, 0, 0, 16'hBBBB, 1, 1, 0, 3'b011);
    for (int i = 0; i < 7; i++)
      addv(0, 0, 1, 0, 0, 0, w2[i], 1, (i == 6) ? 8'd0 : 8'd1, (i == 6), 3'b011);
    addv(1, 1, 0, 0, T3, D3, 0, 0, 1, 0, 3'b011);   // same-cycle edges
    addv(0, 0, 1, 0, 0, 0, 16'hDEAD, 1, 1, 0, 3'b011);
    addv(0, 0, 1, 1, 0, 0, w3[0], 1, 1, 0, 3'b000); // clear errors
    for (int i = 1; i < 6; i++) addv(0, 0, 1, 0, 0, 0, w3[i], 1, 1, 0, 3'b000);
    addv(1, 1, 1, 0, T4, D4, w3[6], 1, 1, 0, 3'b000); // pop and write together
    addv(0, 0, 1, 0, 0, 0, 16'h1234, 1, 1, 0, 3'b000);

    foreach (vq[i]) begin
      tim_en = vq[i].te; dat_en = vq[i].de; tim = vq[i].t; dat = vq[i].d;
      hif.host_rd_en = vq[i].re; hif.host_clr_err = vq[i].cl;
      @(negedge clk);
      chk($sformatf("vec%0d_level", i), hif.host_rec_level, vq[i].xl);
      chk($sformatf("vec%0d_empty", i), hif.host_empty, vq[i].xe);
      chk($sformatf("vec%0d_valid", i), hif.host_rd_valid, vq[i].xv);
      chk($sformatf("vec%0d_err", i), hif.err_flags, vq[i].xr);
      if (vq[i].xv) chk($sformatf("vec%0d_data", i), hif.host_rd_data, vq[i].xd);
    end
    tim_en = 0; dat_en = 0; hif.host_rd_en = 0; hif.host_clr_err = 0;

    // Two-batch pre-alarm dump.
    do_reset();
    scen_dump2(0);

    // Post-alarm dump withheld while the FIFO lacks room for a batch.
    do_reset();
    exp_q.delete();
    sh = ph_tot;
    arm(0, 1, 8'd3);
    serve_batch(1, 50, 100);
    serve_batch(1, 50, 150);
    repeat (10) @(negedge clk);
    chk("hold_pulses_2", ph_tot - sh, 2);
    chk("hold_level_100", hif.host_rec_level, 100);
    chk("hold_busy", hif.busy, 1);
    read_recs(21);
    repeat (8) @(negedge clk);
    chk("hold_level_79", hif.host_rec_level, 79);
    chk("hold_withheld_at_79", ph_tot - sh, 2);
    read_recs(1);
    repeat (8) @(negedge clk);
    chk("hold_issued_at_78", ph_tot - sh, 3);
    read_recs(28);
    chk("hold_level_50", hif.host_rec_level, 50);

    // Reset while RdStar is high drops it at once.
    do_reset();
    arm(1, 0, 8'd1);
    wait_rdstar(0);
    rst = 1;
    #1;
    chk("rst_req_rdstar", rdstar_l, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    // Reset during WAIT_LO with 30 records stored.
    arm(1, 0, 8'd1);
    wait_rdstar(0);
    repeat (2) @(negedge clk);
    sw_l = 1;
    for (int k = 0; k < 30; k++) send_rec(64'(k), 64'(k));
    chk("rstlo_level_30", hif.host_rec_level, 30);
    rst = 1;
    #1;
    chk("rstlo_rdstar_l", rdstar_l, 0);
    chk("rstlo_rdstar_h", rdstar_h, 0);
    chk("rstlo_level", hif.host_rec_level, 0);
    chk("rstlo_empty", hif.host_empty, 1);
    chk("rstlo_busy", hif.busy, 0);
    @(negedge clk);
    rst = 0; sw_l = 0;
    @(negedge clk);
    scen_dump2(1);  // both dump pulses: L wins

    // Wait timeout on the short-timeout instance.
    tif.host_dump_L = 1; tif.host_batches = 8'd1;
    @(negedge clk);
    tif.host_dump_L = 0;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (t_rdstar_l) seen = 1; else @(negedge clk);
    end
    chk("tmo_rdstar_seen", seen, 1);
    tw = 0;
    for (int i = 0; i < 50 && t_rdstar_l; i++) begin
      tw++;
      @(negedge clk);
    end
    chk("tmo_rdstar_width", tw, 4);
    repeat (99) @(negedge clk);
    chk("tmo_err_before", tif.err_flags, 3'b000);
    chk("tmo_busy_before", tif.busy, 1);
    @(negedge clk);
    chk("tmo_err_at_100", tif.err_flags, 3'b100);
    chk("tmo_busy_after", tif.busy, 0);
    tif.host_clr_err = 1;
    @(negedge clk);
    tif.host_clr_err = 0;
    chk("tmo_err_cleared", tif.err_flags, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ddr_alarm_readbuf.md
Name: ddr_alarm_readbuf

Overview:
- Downstream of the DDR3 alarm-record controller.
- Pairs each read-back timing word and sample word into one 128-bit record and buffers the records in a FIFO.
- Serialises records as 16-bit words to the flexbus host.
- Paces the controller by pulsing ddrL_RdStar/ddrH_RdStar, one batch at a time, only while the FIFO has room for a whole batch.

Parameters:
- REC_DEPTH, 128: FIFO depth in 128-bit records; power of two.
- BATCH_RECS, 50: records delivered per RdStar pulse (100 DDR address units / 2).
- RDSTAR_W, 4: RdStar pulse width in clk cycles.
- WAIT_TMO, 65535: cycles allowed for the controller's read_switch to rise then fall before the batch is abandoned.

Ports:
- clk in 1: system clock.
- rst in 1: asynchronous active-high reset.
- ddr_dat_timing in 64: timing word read back from DDR.
- ddr_timing_en in 1: timing word valid.
- ddr_dat in 64: sample word read back from DDR.
- ddr_dat_en in 1: sample word valid (level, may stay high for more than 1 cycle).
- ddrL_read_switch in 1: controller busy reading the pre-alarm region.
- ddrH_read_switch in 1: controller busy reading the post-alarm region.
- ddrL_RdStar out 1: batch request, pre-alarm region.
- ddrH_RdStar out 1: batch request, post-alarm region.
- host_dump_L in 1: pulse; arm a pre-alarm dump of host_batches batches.
- host_dump_H in 1: pulse; arm a post-alarm dump of host_batches batches.
- host_batches in 8: number of batches to dump; 0 is ignored.
- host_rd_en in 1: pop one 16-bit word.
- host_rd_data out 16: word popped, registered.
- host_rd_valid out 1: host_rd_data valid.
- host_empty out 1: no whole word available.
- host_rec_level out 8: number of records stored.
- busy out 1: dump in progress.
- err_flags out 3: sticky; [0] orphan data, [1] timing overwritten, [2] wait timeout.
- host_clr_err in 1: clear err_flags.

Behaviour:
- Reset values: all outputs 0 except host_empty=1. FIFO pointers 0, FSM IDLE, pending-timing flag 0.
- Record pairing:
  - Rising edge of ddr_timing_en latches ddr_dat_timing into the hold register and sets pending.
  - A second timing edge while pending overwrites the hold register and sets err[1].
  - Rising edge of ddr_dat_en with pending writes {hold, ddr_dat} into the FIFO the same cycle and clears pending.
  - Data edge with no pending: discard and set err[0].
  - Timing and data edges in the same cycle: the timing value goes to the hold register first, then the record is written.
  - A write when the FIFO is full is dropped. Unreachable by design, because requests are gated on free space.
- Serialiser word order within a record: timing[63:48], timing[47:32], timing[31:16], timing[15:0], dat[63:48], dat[47:32], dat[31:16], dat[15:0].
- 3-bit word index. The record pops from the FIFO after word 7 is read.
- host_rd_en while not empty: host_rd_data and host_rd_valid update on the next cycle (latency 1).
- host_rd_en while empty is ignored and host_rd_valid stays 0.
- Simultaneous write and pop are both honoured; the level is unchanged.
- Request FSM:
  - IDLE: if batches_left>0 and free records >= BATCH_RECS, go to REQ.
  - REQ: drive the selected RdStar high for RDSTAR_W cycles, then go to WAIT_HI.
  - WAIT_HI: wait for the selected read_switch = 1, then go to WAIT_LO.
  - WAIT_LO: wait for the selected read_switch = 0, then decrement batches_left and go to IDLE.
  - Timeout: a counter starting at REQ exit. If it reaches WAIT_TMO in WAIT_HI or WAIT_LO, set err[2], clear batches_left and go to IDLE.
- Arming:
  - host_dump_L/H in IDLE with batches_left==0 loads host_batches and selects the bank.
  - Arming while busy is ignored.
  - Both dump pulses in the same cycle: L wins.
- busy = (batches_left != 0) or (FSM != IDLE).
- ddrL_RdStar and ddrH_RdStar are never high together, and are never re-pulsed before WAIT_LO completes.
- host_rec_level saturates at 255; width arithmetic uses log2(REC_DEPTH)+1 bits.
- Reset mid-dump aborts immediately: RdStar drops the same cycle (asynchronous), the FIFO is emptied and the hold register is cleared.

Decomposition:
- Shared package:
  - record width 128 and word width 16;
  - FSM state encodings (IDLE, REQ, WAIT_HI, WAIT_LO);
  - err bit indices.
- One sub-module: alarm_rec_fifo, a synchronous 128-bit single-clock FIFO with full, empty and level outputs and asynchronous reset.
- Edge detection is inline.

Test Plan:
1. Arm L with host_batches=2, REC_DEPTH=128. Model: switch rises 3 cycles after RdStar; 50 timing/data pairs; switch falls.
   - Required: ddrL_RdStar high exactly 4 cycles, twice; ddrH_RdStar never high.
   - Required: host_rec_level=100; busy drops after the second WAIT_LO.
2. Timing=0x0123_4567_89AB_CDEF with data=0x1111_2222_3333_4444; then 8 host_rd_en.
   - Required words in order: 0x0123, 0x4567, 0x89AB, 0xCDEF, 0x1111, 0x2222, 0x3333, 0x4444.
   - Required: each word one cycle after its rd_en; host_empty=1 afterwards.
3. Arm H with host_batches=3; fill with 100 records, host does not read.
   - Required: after 2 batches, third RdStar withheld (free=28 < 50).
   - Read 50 records (400 words) -> third ddrH_RdStar pulse issued.
4. Data edge with no prior timing -> err_flags=3'b001, level unchanged.
   - Then two timing edges followed by one data edge -> err_flags=3'b011, one record holding the second timing word.
5. Arm L; model never raises the switch; WAIT_TMO=100.
   - Required: err[2]=1 at cycle 100 after REQ exit; busy=0.
   - host_clr_err -> err_flags=0.
6. Assert rst during WAIT_LO with 30 records stored.
   - Required: RdStar=0 and host_rec_level=0 immediately; host_empty=1.
   - Required: next arm after reset behaves as in scenario 1.
